// File: rtl/tuple_unpacker_if.sv
// rtl/tuple_unpacker_if.sv - tuple input and element output stream bundle for tuple_unpacker
interface tuple_unpacker_if #(
  parameter int DATA_WIDTH  = 128,
  parameter int LANES       = 8,
  parameter int COUNT_WIDTH = 32
);
  logic [LANES*DATA_WIDTH-1:0] i_tuple;
  logic                        i_tuple_write;
  logic                        o_tuple_ready;
  logic                        o_valid;
  logic                        i_ready;
  logic [DATA_WIDTH-1:0]       o_data;
  logic                        o_last;
  logic [COUNT_WIDTH-1:0]      o_run_count;
  logic                        o_overflow;

  modport master (
    output i_tuple, i_tuple_write, i_ready,
    input  o_tuple_ready, o_valid, o_data, o_last, o_run_count, o_overflow
  );

  modport slave (
    input  i_tuple, i_tuple_write, i_ready,
    output o_tuple_ready, o_valid, o_data, o_last, o_run_count, o_overflow
  );
endinterface

// File: rtl/tuple_unpacker.sv
// rtl/tuple_unpacker.sv - buffers merged tuples and serialises nonzero lanes with run markers
module tuple_unpacker #(
  parameter int DATA_WIDTH  = 128,
  parameter int LANES       = 8,
  parameter int DEPTH       = 4,
  parameter int COUNT_WIDTH = 32
) (
  input logic             i_clk,
  input logic             i_rst,
  tuple_unpacker_if.slave bus
);
  localparam int TW    = LANES * DATA_WIDTH;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  typedef enum logic [1:0] {S_EMPTY, S_DATA, S_TERM} state_t;

  logic [TW-1:0]          mem [DEPTH];
  logic [PTR_W-1:0]       wr_ptr, rd_ptr;
  logic [OCC_W-1:0]       occ;
  state_t                 state, state_d;
  logic [TW-1:0]          head_tuple, tuple_d;
  logic [LANES-1:0]       head_mask, mask_d;
  logic [COUNT_WIDTH-1:0] counter;
  logic                   overflow;

  logic                   fifo_empty, fifo_full, hs, head_free, load, pop, bypass, wr_en;
  logic [TW-1:0]          load_src;
  logic [LANES-1:0]       load_mask, cur_bit, rest_mask;
  logic [DATA_WIDTH-1:0]  data_sel;

  assign fifo_empty = (occ == '0);
  assign fifo_full  = (occ == OCC_W'(DEPTH));
  assign hs         = bus.o_valid && bus.i_ready;

  // With the FIFO empty an incoming write goes straight to the head, giving one-cycle latency.
  assign load_src  = fifo_empty ? bus.i_tuple : mem[rd_ptr];
  assign head_free = (state == S_EMPTY) ||
                     (hs && state == S_DATA && rest_mask == '0) ||
                     (hs && state == S_TERM);
  assign load      = head_free && (!fifo_empty || bus.i_tuple_write);
  assign pop       = load && !fifo_empty;
  assign bypass    = load && fifo_empty;
  assign wr_en     = bus.i_tuple_write && !fifo_full && !bypass;

  assign cur_bit   = head_mask & (~head_mask + LANES'(1));
  assign rest_mask = head_mask & ~cur_bit;

  always_comb begin
    load_mask = '0;
    data_sel  = '0;
    for (int k = 0; k < LANES; k++) begin
      load_mask[k] = |load_src[k*DATA_WIDTH +: DATA_WIDTH];
      if (cur_bit[k]) data_sel = head_tuple[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    state_d = state;
    tuple_d = head_tuple;
    mask_d  = head_mask;
    if (state == S_DATA && hs) mask_d = rest_mask;
    if (head_free) begin
      state_d = S_EMPTY;
      if (load) begin
        tuple_d = load_src;
        mask_d  = load_mask;
        state_d = (load_mask == '0) ? S_TERM : S_DATA;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= S_EMPTY;
      head_tuple <= '0;
      head_mask  <= '0;
    end else begin
      state      <= state_d;
      head_tuple <= tuple_d;
      head_mask  <= mask_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      occ      <= '0;
      overflow <= 1'b0;
      counter  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      occ <= occ + OCC_W'(wr_en) - OCC_W'(pop);
      if (bus.i_tuple_write && fifo_full) overflow <= 1'b1;
      if (state == S_DATA && hs && counter != '1) counter <= counter + COUNT_WIDTH'(1);
      else if (state == S_TERM && hs) counter <= '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (wr_en) mem[wr_ptr] <= bus.i_tuple;
  end

  // Two free entries cover the write already in flight behind the merger's registered ready.
  assign bus.o_tuple_ready = (occ <= OCC_W'(DEPTH - 2));
  assign bus.o_valid       = (state != S_EMPTY);
  assign bus.o_data        = (state == S_DATA) ? data_sel : '0;
  assign bus.o_last        = (state == S_TERM);
  assign bus.o_run_count   = (state == S_TERM) ? counter : '0;
  assign bus.o_overflow    = overflow;
endmodule

// File: doc/tuple_unpacker.md
Name: tuple_unpacker

Overview:
- Sits directly downstream of the 8-lane merger.
- Accepts merged 8-element tuples over the merger's write/ready handshake and buffers them in a small tuple FIFO.
- Serialises each tuple into one element per cycle on a valid/ready stream, with end-of-run framing and per-run element counts.
- Feeds the scalar writeback / DRAM-packing stage.

Parameters:
DATA_WIDTH, 128, width of one element
LANES, 8, elements per tuple (lane 0 = smallest)
DEPTH, 4, tuple buffer entries (power of 2, >=2)
COUNT_WIDTH, 32, width of per-run element counter

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous active-high reset
i_tuple  in  LANES*DATA_WIDTH  tuple from merger (lane k = bits [k*DATA_WIDTH +: DATA_WIDTH])
i_tuple_write  in  1  tuple valid this cycle (merger write strobe)
o_tuple_ready  out  1  space available; drives merger's output-ready input
o_valid  out  1  output element valid
i_ready  in  1  downstream accepts element
o_data  out  DATA_WIDTH  output element
o_last  out  1  current beat is end-of-run marker
o_run_count  out  COUNT_WIDTH  data elements in the run; meaningful only when o_last=1
o_overflow  out  1  sticky: write arrived while buffer full

Behaviour:
- Reset (i_rst=1 at posedge):
  - Buffer emptied; head state EMPTY; counter=0; overflow cleared.
  - o_valid=0, o_last=0, o_data=0, o_run_count=0.
  - o_tuple_ready=1 from the first cycle after reset.
  - Reset mid-run discards all buffered tuples and any partial count.
- Tuple buffer:
  - DEPTH-entry circular FIFO with wrapping read/write pointers and an occupancy counter (0..DEPTH).
  - o_tuple_ready is combinational from occupancy: 1 iff free entries >= 2.
  - The 2-entry slack absorbs the merger's one-cycle registered ready: one write may arrive the cycle after ready falls.
  - A write when occupancy==DEPTH is dropped and sets o_overflow, which holds until reset.
  - Simultaneous write and pop in one cycle leaves occupancy unchanged.
- Head register: holds the tuple being serialised, its lane mask, and state.
  - A terminator tuple is one with all lanes zero.
  - Any other tuple is data. Zero lanes inside a data tuple are padding and are never emitted.
- State machine:
  - EMPTY:
    - o_valid=0.
    - If the FIFO is non-empty, pop into head.
    - A terminator loads to TERM.
    - A data tuple loads to DATA, with mask = bit k set iff lane k != 0.
  - DATA:
    - o_valid=1; o_data = lane at the lowest set mask bit; o_last=0.
    - On handshake (o_valid & i_ready): clear that bit and increment counter (saturating at all-ones).
    - If that was the last set bit, pop the next tuple in the same cycle if available (no bubble), otherwise go to EMPTY.
  - TERM:
    - o_valid=1, o_data=0, o_last=1, o_run_count=counter.
    - On handshake: clear counter to 0, then load the next tuple or go to EMPTY.
    - An empty run (terminator with counter 0) still emits one marker beat with count 0.
- Output timing and stability:
  - o_valid, o_data, o_last and o_run_count are functions of registered state only; there is no combinational path from i_ready to them.
  - While o_valid=1 and i_ready=0, all outputs hold stable.
- Latency and throughput:
  - A write at cycle t is visible on o_valid at cycle t+1 when the head is EMPTY.
  - Sustained throughput is 1 element per cycle.
- Unused ready: i_tuple is ignored when i_tuple_write=0.

Test Plan:
- Basic serialisation:
  - Stimulus: reset, then write tuple lanes 0..7 = 1..8, then an all-zero tuple, i_ready=1.
  - Required: first beat cycle after write; data 1,2,..,8 on consecutive cycles; then beat o_last=1, o_data=0, o_run_count=8.
- Padding skip:
  - Stimulus: tuple lanes = {0,0,5,0,7,9,0,11} then terminator.
  - Required: beats 5,7,9,11; then last with count 4.
- Back-to-back and backpressure:
  - Stimulus: 3 data tuples (24 nonzero values) then terminator, with i_ready toggling 1,0 each cycle.
  - Required: 24 data beats in order, outputs stable on stall cycles, no bubbles between tuples when i_ready=1; count=24.
- Flow control:
  - Stimulus: hold i_ready=0 while writing tuples each cycle that o_tuple_ready was high on the previous cycle.
  - Required: o_tuple_ready falls when occupancy reaches DEPTH-1=3; the in-flight write lands as the 4th entry; o_overflow stays 0.
- Overflow and empty run:
  - Forced write with buffer full → tuple dropped and o_overflow=1 until reset.
  - Two consecutive terminators → second marker beat has count 0.
- Reset mid-run:
  - Stimulus: assert i_rst after 3 data beats of a run.
  - Required: o_valid=0 next cycle; new run after reset reports count from 0.
